// File: rtl/dut_port_arbiter_if.sv
// Client request/response pins plus the register-block write/read pins handled by dut_port_arbiter.
interface dut_port_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned DATA_W  = 1
);
    logic [NUM_REQ-1:0]        wr_req_valid;
    logic [NUM_REQ*ADDR_W-1:0] wr_req_addr;
    logic [NUM_REQ*DATA_W-1:0] wr_req_data;
    logic [NUM_REQ-1:0]        wr_req_ready;
    logic [NUM_REQ-1:0]        rd_req_valid;
    logic [NUM_REQ*ADDR_W-1:0] rd_req_addr;
    logic [NUM_REQ-1:0]        rd_req_ready;
    logic [NUM_REQ-1:0]        rd_resp_valid;
    logic [DATA_W-1:0]         rd_resp_data;

    logic [ADDR_W-1:0]         write_address;
    logic [DATA_W-1:0]         write_data;
    logic                      write_en;
    logic                      write_rdy;
    logic [ADDR_W-1:0]         read_address;
    logic                      read_en;
    logic [DATA_W-1:0]         read_data;
    logic                      read_rdy;

    // Arbiter side
    modport slave (
        input  wr_req_valid, wr_req_addr, wr_req_data, rd_req_valid, rd_req_addr,
               write_rdy, read_data, read_rdy,
        output wr_req_ready, rd_req_ready, rd_resp_valid, rd_resp_data,
               write_address, write_data, write_en, read_address, read_en
    );

    // Clients plus register block side
    modport master (
        output wr_req_valid, wr_req_addr, wr_req_data, rd_req_valid, rd_req_addr,
               write_rdy, read_data, read_rdy,
        input  wr_req_ready, rd_req_ready, rd_resp_valid, rd_resp_data,
               write_address, write_data, write_en, read_address, read_en
    );
endinterface

// File: rtl/dut_port_arbiter.sv
// Round-robin sharing of the register block's single write and read ports among NUM_REQ clients,
// each channel with a one-entry issue stage; read responses are routed back to the issuing client.
module dut_port_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned DATA_W  = 1
) (
    input  logic              clk,
    input  logic              reset,
    dut_port_arbiter_if.slave bus
);
    localparam int unsigned     ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    logic                wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [ID_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic                rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [ID_W-1:0]     rd_id_q, rd_id_d;
    logic [ID_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;

    logic                wr_fire, wr_open, wr_any;
    logic                rd_fire, rd_open, rd_any;
    logic                hazard;
    logic [ID_W-1:0]     wr_win, rd_win;
    logic [NUM_REQ-1:0]  wr_grant, rd_grant;

    // First requester found scanning upward from ptr+1 with wrap; returns {found, index}.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [ID_W-1:0]    ptr);
        logic            found;
        logic [ID_W-1:0] win;
        int unsigned     idx;
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[ID_W'(idx)]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
        return {found, win};
    endfunction

    always_comb begin
        wr_fire = wr_valid_q & bus.write_rdy;
        wr_open = !reset & (!wr_valid_q | wr_fire);
        {wr_any, wr_win} = wr_open ? rr_pick(bus.wr_req_valid, wr_ptr_q) : '0;
        wr_grant = wr_any ? (NUM_REQ'(1) << wr_win) : '0;

        // A staged read never overtakes a staged write to the same address.
        hazard  = wr_valid_q & (wr_addr_q == rd_addr_q);
        rd_fire = rd_valid_q & bus.read_rdy & !hazard;
        rd_open = !reset & (!rd_valid_q | rd_fire);
        {rd_any, rd_win} = rd_open ? rr_pick(bus.rd_req_valid, rd_ptr_q) : '0;
        rd_grant = rd_any ? (NUM_REQ'(1) << rd_win) : '0;
    end

    always_comb begin
        wr_valid_d   = wr_valid_q & !wr_fire;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_ptr_d     = wr_ptr_q;
        rd_valid_d   = rd_valid_q & !rd_fire;
        rd_addr_d    = rd_addr_q;
        rd_id_d      = rd_id_q;
        rd_ptr_d     = rd_ptr_q;
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;

        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (wr_any && wr_win == ID_W'(i)) begin
                wr_valid_d = 1'b1;
                wr_addr_d  = bus.wr_req_addr[i*ADDR_W +: ADDR_W];
                wr_data_d  = bus.wr_req_data[i*DATA_W +: DATA_W];
                wr_ptr_d   = wr_win;
            end
            if (rd_any && rd_win == ID_W'(i)) begin
                rd_valid_d = 1'b1;
                rd_addr_d  = bus.rd_req_addr[i*ADDR_W +: ADDR_W];
                rd_id_d    = rd_win;
                rd_ptr_d   = rd_win;
            end
        end

        if (rd_fire) begin
            resp_valid_d = NUM_REQ'(1) << rd_id_q;
            resp_data_d  = bus.read_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_ptr_q     <= LAST_ID;
            rd_valid_q   <= 1'b0;
            rd_addr_q    <= '0;
            rd_id_q      <= '0;
            rd_ptr_q     <= LAST_ID;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            wr_valid_q   <= wr_valid_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_valid_q   <= rd_valid_d;
            rd_addr_q    <= rd_addr_d;
            rd_id_q      <= rd_id_d;
            rd_ptr_q     <= rd_ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign bus.wr_req_ready  = wr_grant;
    assign bus.rd_req_ready  = rd_grant;
    assign bus.write_en      = wr_fire;
    assign bus.write_address = wr_addr_q;
    assign bus.write_data    = wr_data_q;
    assign bus.read_en       = rd_fire;
    assign bus.read_address  = rd_addr_q;
    assign bus.rd_resp_valid = resp_valid_q;
    assign bus.rd_resp_data  = resp_data_q;
endmodule

// File: tb/tb_dut_port_arbiter.sv
// Bench for dut_port_arbiter: directed scenarios plus random traffic against a behavioural model,
// with a small register-block memory standing in for dut.
module tb_dut_port_arbiter;
    localparam int unsigned NR    = 2;
    localparam int unsigned AW    = 3;
    localparam int unsigned DW    = 1;
    localparam int unsigned DEPTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dut_port_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    dut_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    // Register block stand-in: write at the edge, combinational read.
    logic [DW-1:0] dut_mem [DEPTH];
    always @(posedge clk) if (bus.write_en === 1'b1) dut_mem[bus.write_address] <= bus.write_data;
    assign bus.read_data = dut_mem[bus.read_address];

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: stages as valid/content pairs, pointers as ints, pending response.
    int            m_wptr, m_rptr, m_rid, m_pid;
    bit            m_wv, m_rv, m_pend;
    logic [AW-1:0] m_wa, m_ra;
    logic [DW-1:0] m_wd, m_pdata;
    logic [DW-1:0] m_mem [DEPTH];

    function automatic int rr(input logic [NR-1:0] req, input int ptr);
        for (int k = 1; k <= int'(NR); k++)
            if (req[(ptr + k) % NR]) return (ptr + k) % NR;
        return -1;
    endfunction

    always @(negedge clk) begin : compare
        int  wg, rg;
        bit  ew, er, hz;
        if (reset) begin
            check("rst_wr_ready", 32'(bus.wr_req_ready), 0);
            check("rst_rd_ready", 32'(bus.rd_req_ready), 0);
            check("rst_write_en", 32'(bus.write_en), 0);
            check("rst_read_en", 32'(bus.read_en), 0);
            check("rst_resp_valid", 32'(bus.rd_resp_valid), 0);
            check("rst_resp_data", 32'(bus.rd_resp_data), 0);
            check("rst_write_addr", 32'(bus.write_address), 0);
            check("rst_read_addr", 32'(bus.read_address), 0);
            m_wptr = NR - 1; m_rptr = NR - 1;
            m_wv = 0; m_rv = 0; m_pend = 0;
            m_wa = '0; m_wd = '0; m_ra = '0; m_rid = 0; m_pid = 0; m_pdata = '0;
        end else begin
            ew = m_wv && bus.write_rdy;
            wg = (!m_wv || ew) ? rr(bus.wr_req_valid, m_wptr) : -1;
            hz = m_wv && (m_wa == m_ra);
            er = m_rv && bus.read_rdy && !hz;
            rg = (!m_rv || er) ? rr(bus.rd_req_valid, m_rptr) : -1;

            check("wr_req_ready", 32'(bus.wr_req_ready), (wg >= 0) ? (1 << wg) : 0);
            check("rd_req_ready", 32'(bus.rd_req_ready), (rg >= 0) ? (1 << rg) : 0);
            check("write_en", 32'(bus.write_en), 32'(ew));
            check("read_en", 32'(bus.read_en), 32'(er));
            check("write_address", 32'(bus.write_address), 32'(m_wa));
            check("write_data", 32'(bus.write_data), 32'(m_wd));
            check("read_address", 32'(bus.read_address), 32'(m_ra));
            check("rd_resp_valid", 32'(bus.rd_resp_valid), m_pend ? (1 << m_pid) : 0);
            if (m_pend) check("rd_resp_data", 32'(bus.rd_resp_data), 32'(m_pdata));

            m_pend = er;
            if (er) begin
                m_pid   = m_rid;
                m_pdata = m_mem[m_ra];
            end
            if (ew) m_mem[m_wa] = m_wd;
            if (wg >= 0) begin
                m_wv = 1; m_wptr = wg;
                m_wa = bus.wr_req_addr[wg*AW +: AW];
                m_wd = bus.wr_req_data[wg*DW +: DW];
            end else if (ew) m_wv = 0;
            if (rg >= 0) begin
                m_rv = 1; m_rptr = rg; m_rid = rg;
                m_ra = bus.rd_req_addr[rg*AW +: AW];
            end else if (er) m_rv = 0;
        end
    end

    task automatic set_wr(input int c, input bit v, input int a, input int d);
        bus.wr_req_valid[c]          = v;
        bus.wr_req_addr[c*AW +: AW]  = AW'(a);
        bus.wr_req_data[c*DW +: DW]  = DW'(d);
    endtask

    task automatic set_rd(input int c, input bit v, input int a);
        bus.rd_req_valid[c]         = v;
        bus.rd_req_addr[c*AW +: AW] = AW'(a);
    endtask

    task automatic idle();
        bus.wr_req_valid = '0;
        bus.rd_req_valid = '0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next();
        reset = 1'b1;
        idle();
        bus.write_rdy = 1'b1;
        bus.read_rdy  = 1'b1;
        next();
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0] alt [4];
        alt = '{2'b01, 2'b10, 2'b01, 2'b10};
        for (int i = 0; i < int'(DEPTH); i++) begin
            dut_mem[i] = '0;
            m_mem[i]   = '0;
        end
        idle();
        bus.wr_req_addr = '0; bus.wr_req_data = '0; bus.rd_req_addr = '0;
        bus.write_rdy = 1'b1;
        bus.read_rdy  = 1'b1;

        // Reset state and a single write then read-back of address 5
        @(negedge clk);
        check("reset_write_en_lit", 32'(bus.write_en), 0);
        check("reset_resp_lit", 32'(bus.rd_resp_valid), 0);
        next();
        reset = 1'b0;
        set_wr(0, 1, 5, 1);
        @(negedge clk);
        check("t1_wr_ready_lit", 32'(bus.wr_req_ready), 1);
        next();
        set_wr(0, 0, 0, 0);
        set_rd(0, 1, 5);
        @(negedge clk);
        check("t1_write_en_lit", 32'(bus.write_en), 1);
        check("t1_write_addr_lit", 32'(bus.write_address), 5);
        check("t1_write_data_lit", 32'(bus.write_data), 1);
        check("t1_rd_ready_lit", 32'(bus.rd_req_ready), 1);
        next();
        set_rd(0, 0, 0);
        @(negedge clk);
        check("t1_read_en_lit", 32'(bus.read_en), 1);
        check("t1_read_addr_lit", 32'(bus.read_address), 5);
        next();
        @(negedge clk);
        check("t1_resp_valid_lit", 32'(bus.rd_resp_valid), 1);
        check("t1_resp_data_lit", 32'(bus.rd_resp_data), 1);

        // Two clients contending: grants alternate, write_en high back to back
        do_reset();
        set_wr(0, 1, 1, 1);
        set_wr(1, 1, 3, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_alt_grant_lit", 32'(bus.wr_req_ready), 32'(alt[i]));
            if (i > 0) check("t2_write_en_lit", 32'(bus.write_en), 1);
            next();
        end
        idle();
        @(negedge clk);
        check("t2_write_en_last_lit", 32'(bus.write_en), 1);

        // write_rdy stall holds the staged write and blocks new grants
        do_reset();
        set_wr(0, 1, 4, 1);
        @(negedge clk);
        check("t3_first_grant_lit", 32'(bus.wr_req_ready), 1);
        next();
        bus.write_rdy = 1'b0;
        set_wr(0, 0, 0, 0);
        set_wr(1, 1, 6, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_stall_write_en_lit", 32'(bus.write_en), 0);
            check("t3_stall_ready_lit", 32'(bus.wr_req_ready), 0);
            next();
        end
        bus.write_rdy = 1'b1;
        @(negedge clk);
        check("t3_resume_en_lit", 32'(bus.write_en), 1);
        check("t3_resume_addr_lit", 32'(bus.write_address), 4);
        check("t3_resume_grant_lit", 32'(bus.wr_req_ready), 2);
        next();
        idle();
        @(negedge clk);
        check("t3_second_addr_lit", 32'(bus.write_address), 6);
        check("t3_second_en_lit", 32'(bus.write_en), 1);

        // Read of address 2 waits for the write to address 2 staged alongside it
        do_reset();
        set_rd(0, 1, 2);
        set_wr(1, 1, 2, 1);
        @(negedge clk);
        check("t4_rd_ready_lit", 32'(bus.rd_req_ready), 1);
        check("t4_wr_ready_lit", 32'(bus.wr_req_ready), 2);
        next();
        idle();
        @(negedge clk);
        check("t4_write_en_lit", 32'(bus.write_en), 1);
        check("t4_read_blocked_lit", 32'(bus.read_en), 0);
        next();
        @(negedge clk);
        check("t4_read_en_lit", 32'(bus.read_en), 1);
        next();
        @(negedge clk);
        check("t4_resp_valid_lit", 32'(bus.rd_resp_valid), 1);
        check("t4_resp_data_lit", 32'(bus.rd_resp_data), 1);

        // Continuous reads from both clients with read_rdy toggling
        do_reset();
        set_rd(0, 1, 3);
        set_rd(1, 1, 5);
        for (int i = 0; i < 12; i++) begin
            bus.read_rdy = 1'(i % 2);
            next();
        end
        idle();
        bus.read_rdy = 1'b1;
        repeat (3) next();

        // Reset asserted with both stages full clears outputs immediately
        do_reset();
        bus.write_rdy = 1'b0;
        bus.read_rdy  = 1'b0;
        set_wr(1, 1, 7, 1);
        set_rd(1, 1, 6);
        next();
        idle();
        bus.write_rdy = 1'b1;
        bus.read_rdy  = 1'b1;
        #1;
        check("t6_pre_write_en_lit", 32'(bus.write_en), 1);
        check("t6_pre_read_addr_lit", 32'(bus.read_address), 6);
        reset = 1'b1;
        #1;
        check("t6_async_write_en_lit", 32'(bus.write_en), 0);
        check("t6_async_read_en_lit", 32'(bus.read_en), 0);
        check("t6_async_waddr_lit", 32'(bus.write_address), 0);
        check("t6_async_raddr_lit", 32'(bus.read_address), 0);
        next();
        reset = 1'b0;
        set_wr(0, 1, 1, 0);
        set_wr(1, 1, 2, 0);
        @(negedge clk);
        check("t6_first_winner_lit", 32'(bus.wr_req_ready), 1);
        next();
        idle();
        repeat (2) next();

        // Random traffic, occasional reset
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            bus.write_rdy = ($urandom_range(0, 3) != 0);
            bus.read_rdy  = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < int'(NR); c++) begin
                int amax;
                amax = ($urandom_range(0, 1) == 0) ? 1 : 7;
                set_wr(c, 1'($urandom_range(0, 1)), int'($urandom_range(0, amax)),
                       int'($urandom_range(0, 1)));
                set_rd(c, 1'($urandom_range(0, 1)), int'($urandom_range(0, amax)));
            end
            next();
        end
        reset = 1'b0;
        idle();
        bus.write_rdy = 1'b1;
        bus.read_rdy  = 1'b1;
        repeat (4) next();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
